// File: rtl/bus_trace_pkg.sv
// Shared definitions for the bus trace capture block.
// Holds the capture state encodings, the record width and the record field
// layout {SYNC, RW, AB[15:0], DB[7:0]}, plus a helper that packs a record.
package bus_trace_pkg;

  localparam int RECW     = 26;
  localparam int SYNC_BIT = 25;
  localparam int RW_BIT   = 24;
  localparam int AB_MSB   = 23;
  localparam int AB_LSB   = 8;
  localparam int DB_MSB   = 7;
  localparam int DB_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  function automatic logic [RECW-1:0] pack_rec(input logic        sync,
                                               input logic        rw,
                                               input logic [15:0] ab,
                                               input logic [7:0]  db);
    return {sync, rw, ab, db};
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port record RAM for the bus trace buffer.
// One write port and one read port on the same clock. The read is
// read-first (a same-cycle write to the read slot returns the old word) and
// the output is registered, giving one cycle of read latency.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears only the read register
//   we       - write enable
//   wr_addr  - write slot
//   wr_data  - record to write
//   rd_addr  - read slot
//   rd_data  - registered read data
module trace_ram #(
  parameter int AW   = 8,
  parameter int RECW = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [RECW-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [RECW-1:0] rd_data
);

  logic [RECW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Non-blocking write above plus this read of the pre-edge array gives
  // read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bus_trace_capture.sv
// Logic-analyser capture of the 6502 core external bus.
// Samples the core bus on every falling edge of the (asynchronous) PHI2
// clock, writes one record per bus cycle into a circular RAM while armed,
// triggers on an opcode fetch from a programmable address and freezes after
// a programmable number of post-trigger records.
// Ports:
//   CLK_50MHZ   - system clock
//   RST_N       - asynchronous active-low reset
//   PHI2        - core cp2, asynchronous to CLK_50MHZ
//   AB/DB/RW/SYNC - core bus nodes
//   ARM         - level, capture enabled while high
//   TRIG_EN     - enable address trigger
//   TRIG_ADDR   - trigger address (opcode fetch match)
//   POST_COUNT  - records captured after the trigger record
//   RD_ADDR     - physical read slot
//   RD_DATA     - record at RD_ADDR, one cycle latency
//   STATE       - 00 IDLE, 01 ARMED, 10 POST, 11 DONE
//   WR_PTR      - next write slot (oldest slot once wrapped)
//   TRIG_PTR    - slot holding the trigger record
//   FILL        - valid records, saturating at 2**AW
module bus_trace_capture #(
  parameter int AW   = 8,
  parameter int RECW = bus_trace_pkg::RECW
) (
  input  logic            CLK_50MHZ,
  input  logic            RST_N,
  input  logic            PHI2,
  input  logic [15:0]     AB,
  input  logic [7:0]      DB,
  input  logic            RW,
  input  logic            SYNC,
  input  logic            ARM,
  input  logic            TRIG_EN,
  input  logic [15:0]     TRIG_ADDR,
  input  logic [AW-1:0]   POST_COUNT,
  input  logic [AW-1:0]   RD_ADDR,
  output logic [RECW-1:0] RD_DATA,
  output logic [1:0]      STATE,
  output logic [AW-1:0]   WR_PTR,
  output logic [AW-1:0]   TRIG_PTR,
  output logic [AW:0]     FILL
);

  import bus_trace_pkg::*;

  localparam logic [AW:0] FILL_MAX = (AW+1)'(1 << AW);

  logic            phi2_p0, phi2_p1;
  logic [15:0]     ab_p0, ab_p1;
  logic [7:0]      db_p0, db_p1;
  logic            rw_p0, rw_p1;
  logic            sync_p0, sync_p1;

  logic            cap;
  logic            trig_hit;
  logic            we;
  logic [RECW-1:0] rec;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   trig_ptr;
  logic [AW:0]     fill;
  logic [AW-1:0]   post_cnt;

  // Stage p0/p1: PHI2 synchroniser
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      phi2_p0 <= 1'b0;
      phi2_p1 <= 1'b0;
    end else begin
      phi2_p0 <= PHI2;
      phi2_p1 <= phi2_p0;
    end
  end

  // Stage p0/p1: bus delay matching the synchroniser, so the record seen at
  // the strobe is the one sampled while PHI2 was still high
  always_ff @(posedge CLK_50MHZ) begin
    ab_p0   <= AB;
    ab_p1   <= ab_p0;
    db_p0   <= DB;
    db_p1   <= db_p0;
    rw_p0   <= RW;
    rw_p1   <= rw_p0;
    sync_p0 <= SYNC;
    sync_p1 <= sync_p0;
  end

  // Falling edge of the synchronised PHI2: exactly one strobe per bus cycle
  assign cap      = phi2_p1 & ~phi2_p0;
  assign rec      = pack_rec(sync_p1, rw_p1, ab_p1, db_p1);
  assign trig_hit = TRIG_EN & sync_p1 & (ab_p1 == TRIG_ADDR);
  // ARM low wins over a coincident strobe
  assign we       = cap & ARM & ((state == ST_ARMED) || (state == ST_POST));

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      trig_ptr <= '0;
      fill     <= '0;
      post_cnt <= '0;
    end else if (!ARM) begin
      // Pointers are kept so a stopped capture can still be read out
      state <= ST_IDLE;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          state    <= ST_ARMED;
          wr_ptr   <= '0;
          trig_ptr <= '0;
          fill     <= '0;
        end
        ST_ARMED: begin
          if (cap && trig_hit) begin
            trig_ptr <= wr_ptr;
            if (POST_COUNT == '0) begin
              state <= ST_DONE;
            end else begin
              post_cnt <= POST_COUNT;
              state    <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (cap) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  trace_ram #(
    .AW   (AW),
    .RECW (RECW)
  ) u_ram (
    .clk     (CLK_50MHZ),
    .rst_n   (RST_N),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (rec),
    .rd_addr (RD_ADDR),
    .rd_data (RD_DATA)
  );

  assign STATE    = state;
  assign WR_PTR   = wr_ptr;
  assign TRIG_PTR = trig_ptr;
  assign FILL     = fill;

endmodule
